// File: rtl/result_readback.sv
// Result FIFO from the core to the HPS, read over an Avalon-MM slave.
// Optional threshold/overflow interrupt enabled by RESULT_IRQ_EN.
module result_readback #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              result_write,
    input  logic [DATA_W-1:0] result_writedata,
    output logic              result_full,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              irq
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = ADDR_W + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DROPS  = 2'd2;
    localparam logic [1:0] A_THRESH = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [15:0]   drops_q, drops_d;
    logic [PW-1:0] thresh_q, thresh_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q;
    logic          irq_q, irq_d;

    logic          empty;
    logic          full;
    logic [PW-1:0] level;
    logic          push;
    logic          drop;
    logic          rd_data;
    logic          pop;
    logic          unf_ev;
    logic          wr_status;
    logic          wr_drops;
    logic          wr_thresh;
    logic [31:0]   status;
    logic          unused_wdata;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // Full comes from registered pointers, so a same-cycle pop never frees room.
    assign push    = result_write && !full;
    assign drop    = result_write && full;
    assign rd_data = avs_read && (avs_address == A_DATA);
    assign pop     = rd_data && !empty;
    assign unf_ev  = rd_data && empty;

    assign wr_status = avs_write && (avs_address == A_STATUS);
    assign wr_drops  = avs_write && (avs_address == A_DROPS);
    assign wr_thresh = avs_write && (avs_address == A_THRESH);

    assign status = {12'd0, unf_q, ovf_q, full, empty, 16'(level)};

    assign unused_wdata = ^avs_writedata;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        drops_d  = drops_q;
        thresh_d = thresh_q;
        rdata_d  = rdata_q;
        irq_d    = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        // Event updates follow clears so a coincident event wins.
        if (wr_status && avs_writedata[18]) ovf_d = 1'b0;
        if (wr_status && avs_writedata[19]) unf_d = 1'b0;
        if (wr_drops) drops_d = '0;
        if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
            else                     drops_d = drops_q;
        end
        if (unf_ev) unf_d = 1'b1;

`ifdef RESULT_IRQ_EN
        if (wr_thresh) thresh_d = avs_writedata[ADDR_W:0];
        irq_d = ((level >= thresh_q) && (thresh_q != '0)) || ovf_q;
`else
        thresh_d = '0;
`endif

        if (avs_read) begin
            unique case (avs_address)
                A_DATA:   rdata_d = empty ? 32'd0
                                          : 32'(mem[rd_ptr_q[ADDR_W-1:0]]);
                A_STATUS: rdata_d = status;
                A_DROPS:  rdata_d = {16'd0, drops_q};
                A_THRESH: rdata_d = 32'(thresh_q);
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            drops_q  <= '0;
`ifdef RESULT_IRQ_EN
            thresh_q <= PW'(1);
`else
            thresh_q <= '0;
`endif
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            drops_q  <= drops_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            rvalid_q <= avs_read;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst_n && push) mem[wr_ptr_q[ADDR_W-1:0]] <= result_writedata;
    end

    assign result_full       = full;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_q;

endmodule
